// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor update queue: queue entry layout and default depth.
package bp_pkg;

    localparam int BP_DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
    } bp_entry_t;

endpackage

// File: rtl/bp_update_queue_if.sv
// Resolution-in / BTB-update-out bundle of the update queue.
// The slave modport is the queue itself; the master modport is the execute/BTB side.
interface bp_update_queue_if #(
    parameter int CNT_BITS = 3
);
    logic                res_valid_i;
    logic                res_ready_o;
    logic [31:0]         res_pc_i;
    logic                res_taken_i;
    logic [31:0]         res_target_i;
    logic                update_en_o;
    logic [31:0]         update_pc_o;
    logic                update_taken_o;
    logic [31:0]         update_target_o;
    logic [CNT_BITS-1:0] count_o;

    modport slave (
        input  res_valid_i, res_pc_i, res_taken_i, res_target_i,
        output res_ready_o, update_en_o, update_pc_o, update_taken_o,
               update_target_o, count_o
    );

    modport master (
        output res_valid_i, res_pc_i, res_taken_i, res_target_i,
        input  res_ready_o, update_en_o, update_pc_o, update_taken_o,
               update_target_o, count_o
    );
endinterface

// File: rtl/bp_fifo_ctrl.sv
// Head/tail pointers and occupancy counter for the update queue; pointers wrap
// naturally because DEPTH is a power of two.
module bp_fifo_ctrl #(
    parameter  int DEPTH    = 4,
    parameter  int CNT_BITS = 3,
    localparam int PTR_BITS = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push_i,
    input  logic                pop_i,
    output logic [PTR_BITS-1:0] head_o,
    output logic [PTR_BITS-1:0] tail_o,
    output logic [CNT_BITS-1:0] count_o,
    output logic                full_o,
    output logic                empty_o
);
    logic [PTR_BITS-1:0] head_q, head_d;
    logic [PTR_BITS-1:0] tail_q, tail_d;
    logic [CNT_BITS-1:0] count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_i) begin
            tail_d = tail_q + PTR_BITS'(1);
        end
        if (pop_i) begin
            head_d = head_q + PTR_BITS'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_BITS'(1);
            2'b01:   count_d = count_q - CNT_BITS'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign tail_o  = tail_q;
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_BITS'(DEPTH));
    assign empty_o = (count_q == '0);
endmodule

// File: rtl/bp_update_queue.sv
// Queue of taken branch resolutions feeding BTB updates, one drained per cycle.
// Optional macro BPUQ_COALESCE_EN merges a push into the newest entry with the same PC.
module bp_update_queue
    import bp_pkg::*;
#(
    parameter  int DEPTH    = BP_DEFAULT_DEPTH,
    parameter  int CNT_BITS = 3,
    localparam int PTR_BITS = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    bp_update_queue_if.slave bus
);
    bp_entry_t           mem_q [DEPTH];
    logic [PTR_BITS-1:0] head;
    logic [PTR_BITS-1:0] tail;
    logic [CNT_BITS-1:0] count;
    logic                full;
    logic                empty;
    logic                push_req;
    logic                pop;
    logic                coalesce;
    logic                alloc;

    assign push_req = bus.res_valid_i && !full && bus.res_taken_i;
    assign pop      = !empty;

`ifdef BPUQ_COALESCE_EN
    logic [PTR_BITS-1:0] newest;
    assign newest = tail - PTR_BITS'(1);
    // With a single entry the newest one is the head, which pops this cycle.
    assign coalesce = push_req && (count > CNT_BITS'(1))
                      && (mem_q[newest].pc == bus.res_pc_i);
`else
    assign coalesce = 1'b0;
`endif

    assign alloc = push_req && !coalesce;

    bp_fifo_ctrl #(
        .DEPTH    (DEPTH),
        .CNT_BITS (CNT_BITS)
    ) u_ctrl (
        .clk     (clk),
        .rst     (rst),
        .push_i  (alloc),
        .pop_i   (pop),
        .head_o  (head),
        .tail_o  (tail),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (alloc) begin
                mem_q[tail] <= '{pc: bus.res_pc_i, target: bus.res_target_i};
            end
`ifdef BPUQ_COALESCE_EN
            if (coalesce) begin
                mem_q[newest].target <= bus.res_target_i;
            end
`endif
        end
    end

    assign bus.res_ready_o     = !full;
    assign bus.update_en_o     = !empty;
    assign bus.update_taken_o  = !empty;
    assign bus.update_pc_o     = empty ? 32'b0 : mem_q[head].pc;
    assign bus.update_target_o = empty ? 32'b0 : mem_q[head].target;
    assign bus.count_o         = count;
endmodule

// File: tb/tb_bp_update_queue.sv
// Directed table-driven bench for bp_update_queue plus hand-written multi-cycle sequences.
module tb_bp_update_queue;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bp_update_queue_if #(.CNT_BITS(3)) bus ();

    bp_update_queue #(
        .DEPTH    (4),
        .CNT_BITS (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rst;
        logic        valid;
        logic        taken;
        logic [31:0] pc;
        logic [31:0] target;
        logic        expReady;
        logic        expEn;
        logic [31:0] expPc;
        logic [31:0] expTarget;
        logic [2:0]  expCount;
    } vec_t;

    vec_t vecs[$];
    int   assertCount = 0;
    int   failCount   = 0;

    function automatic void addVec(input logic r, v, t, input logic [31:0] pc, tg,
                                   input logic rdy, en, input logic [31:0] ePc, eTg,
                                   input logic [2:0] cnt);
        vec_t x;
        x.rst = r; x.valid = v; x.taken = t; x.pc = pc; x.target = tg;
        x.expReady = rdy; x.expEn = en; x.expPc = ePc; x.expTarget = eTg; x.expCount = cnt;
        vecs.push_back(x);
    endfunction

    // Drive inputs on the falling edge, then let one rising edge act and sample 1ns later.
    task automatic applyStimulus(input logic r, v, t, input logic [31:0] pc, tg);
        @(negedge clk);
        rst              = r;
        bus.res_valid_i  = v;
        bus.res_taken_i  = t;
        bus.res_pc_i     = pc;
        bus.res_target_i = tg;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic rdy, en, input logic [31:0] ePc, eTg,
                            input logic [2:0] cnt);
        checkOutput({tag, ".ready"},  32'(bus.res_ready_o),    32'(rdy));
        checkOutput({tag, ".en"},     32'(bus.update_en_o),    32'(en));
        checkOutput({tag, ".taken"},  32'(bus.update_taken_o), 32'(en));
        checkOutput({tag, ".pc"},     bus.update_pc_o,         ePc);
        checkOutput({tag, ".target"}, bus.update_target_o,     eTg);
        checkOutput({tag, ".count"},  32'(bus.count_o),        32'(cnt));
    endtask

    initial begin
        int waitCycles;
        rst              = 1'b1;
        bus.res_valid_i  = 1'b0;
        bus.res_taken_i  = 1'b0;
        bus.res_pc_i     = '0;
        bus.res_target_i = '0;

        // rst valid taken pc target | ready en pc target count (after the edge)
        addVec(1, 1, 1, 32'h999, 32'h888,  1, 0, 32'h0,   32'h0,    3'd0);
        addVec(0, 0, 0, 32'h0,   32'h0,    1, 0, 32'h0,   32'h0,    3'd0);
        addVec(0, 1, 1, 32'h100, 32'h200,  1, 1, 32'h100, 32'h200,  3'd1);
        addVec(0, 0, 0, 32'h0,   32'h0,    1, 0, 32'h0,   32'h0,    3'd0);
        addVec(0, 1, 0, 32'h104, 32'h300,  1, 0, 32'h0,   32'h0,    3'd0);
        addVec(0, 1, 1, 32'h10,  32'h1010, 1, 1, 32'h10,  32'h1010, 3'd1);
        addVec(0, 1, 1, 32'h20,  32'h1020, 1, 1, 32'h20,  32'h1020, 3'd1);
        addVec(0, 1, 1, 32'h30,  32'h1030, 1, 1, 32'h30,  32'h1030, 3'd1);
        addVec(0, 1, 1, 32'h40,  32'h1040, 1, 1, 32'h40,  32'h1040, 3'd1);
        addVec(0, 0, 1, 32'h50,  32'h1050, 1, 0, 32'h0,   32'h0,    3'd0);
        addVec(0, 1, 1, 32'h500, 32'h5A0,  1, 1, 32'h500, 32'h5A0,  3'd1);
        addVec(1, 1, 1, 32'h600, 32'h6A0,  1, 0, 32'h0,   32'h0,    3'd0);
        addVec(0, 0, 0, 32'h0,   32'h0,    1, 0, 32'h0,   32'h0,    3'd0);
        addVec(0, 0, 0, 32'h0,   32'h0,    1, 0, 32'h0,   32'h0,    3'd0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].taken, vecs[i].pc, vecs[i].target);
            checkAll($sformatf("v%0d", i), vecs[i].expReady, vecs[i].expEn,
                     vecs[i].expPc, vecs[i].expTarget, vecs[i].expCount);
        end

        // Ready must not depend on valid: probe combinationally with a pending not-taken request.
        @(negedge clk);
        bus.res_valid_i = 1'b1;
        bus.res_taken_i = 1'b0;
        #1;
        checkOutput("readyWithValid", 32'(bus.res_ready_o), 32'd1);

        $display("[TB] streaming 10 back-to-back pushes");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 1, 32'h1000 + 32'(i * 4), 32'h8000 + 32'(i));
            checkAll($sformatf("stream%0d", i), 1'b1, 1'b1,
                     32'h1000 + 32'(i * 4), 32'h8000 + 32'(i), 3'd1);
        end

        applyStimulus(0, 0, 0, 32'h0, 32'h0);
        waitCycles = 0;
        while (bus.update_en_o !== 1'b0 && waitCycles < 8) begin
            applyStimulus(0, 0, 0, 32'h0, 32'h0);
            waitCycles++;
        end
        checkOutput("drainTimeout", 32'(waitCycles < 8), 32'd1);
        checkAll("afterStream", 1'b1, 1'b0, 32'h0, 32'h0, 3'd0);

        $display("[TB] same-PC pushes on consecutive cycles");
        applyStimulus(0, 1, 1, 32'h300, 32'hA0);
        checkAll("samePc0", 1'b1, 1'b1, 32'h300, 32'hA0, 3'd1);
        applyStimulus(0, 1, 1, 32'h300, 32'hB0);
        checkAll("samePc1", 1'b1, 1'b1, 32'h300, 32'hB0, 3'd1);
        applyStimulus(0, 0, 0, 32'h0, 32'h0);
        checkAll("samePc2", 1'b1, 1'b0, 32'h0, 32'h0, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
